mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 142 ++++++++++++++
 tb/tb_mem_io_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: a RAM window, a TX FIFO drained by a
// byte stream, and an RX holding register with sticky error flags.
module mem_io_responder #(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [7:0]  mem_out,
    output logic [7:0]  mem_in,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CountFull     = CW'(TX_DEPTH);
    localparam logic [CW-1:0] CountNearFull = CW'(TX_DEPTH - 2);

    logic [7:0]        ram_q [2**RAM_AW];
    logic [7:0]        fifo_q [TX_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [7:0]        mem_in_q, mem_in_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_overflow_q, tx_overflow_d;

    logic              is_io, data_sel, stat_sel, bus_rd, bus_wr;
    logic              tx_pop, tx_push, push_req, tx_full;
    logic              rx_pop, rx_load, stat_rd, ram_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        status, rd_byte;
    logic              unused_addr;

    assign unused_addr = ^mem_addr;

    always_comb begin
        is_io    = (mem_addr[17:16] == 2'b11);
        data_sel = is_io && (mem_addr[2:0] == 3'd0);
        stat_sel = is_io && (mem_addr[2:0] == 3'd4);
        ram_idx  = mem_addr[RAM_AW-1:0];
        bus_rd   = rdy && !mem_wr;
        bus_wr   = rdy && mem_wr;
        ram_we   = bus_wr && !is_io;

        tx_full  = (count_q == CountFull);
        tx_pop   = (count_q != '0) && tx_ready;
        push_req = bus_wr && data_sel;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        tx_push  = push_req && (!tx_full || tx_pop);

        rx_pop   = bus_rd && data_sel;
        stat_rd  = bus_rd && stat_sel;
        rx_load  = rx_valid && (!rx_valid_q || rx_pop);
        status   = {4'b0000, rx_overrun_q, tx_overflow_q, tx_full, rx_valid_q};

        if (!is_io) begin
            rd_byte = ram_q[ram_idx];
        end else if (data_sel) begin
            rd_byte = rx_valid_q ? rx_data_q : 8'h00;
        end else if (stat_sel) begin
            rd_byte = status;
        end else begin
            rd_byte = 8'h00;
        end

        mem_in_d = bus_rd ? rd_byte : mem_in_q;

        count_d = count_q;
        unique case ({tx_push, tx_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rx_valid_d = rx_valid_q && !rx_pop;
        rx_data_d  = rx_data_q;
        if (rx_load) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_data;
        end

        // Status read clears the sticky bits; a same-cycle event re-arms them.
        rx_overrun_d  = stat_rd ? 1'b0 : rx_overrun_q;
        tx_overflow_d = stat_rd ? 1'b0 : tx_overflow_q;
        if (rx_valid && !rx_load) begin
            rx_overrun_d = 1'b1;
        end
        if (push_req && !tx_push) begin
            tx_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_out;
        end
        if (tx_push) begin
            fifo_q[wr_ptr_q] <= mem_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
            mem_in_q      <= 8'h00;
        end else begin
            if (tx_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (tx_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q       <= count_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_overflow_q <= tx_overflow_d;
            mem_in_q      <= mem_in_d;
        end
    end

    assign mem_in         = mem_in_q;
    assign io_buffer_full = (count_q >= CountNearFull);
    assign tx_valid       = (count_q != '0);
    assign tx_data        = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized checks of mem_io_responder against a queue-based
// behavioural model of the RAM, TX FIFO and RX holding register.
module tb_mem_io_responder;
    localparam int unsigned RAM_AW   = 17;
    localparam int unsigned TX_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_addr;
    logic [7:0]  mem_out, rx_data, mem_in, tx_data;
    logic        io_buffer_full, tx_valid;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_txq [$];
    bit         m_rxv, m_ovf, m_ovr;
    logic [7:0] m_rxd, m_mem_in;
    bit         g_trdy;

    mem_io_responder #(.RAM_AW(RAM_AW), .TX_DEPTH(TX_DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_out(mem_out), .mem_in(mem_in), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input logic [31:0] a, input bit w,
                              input logic [7:0] d, input bit trdy, input bit rv,
                              input logic [7:0] rd);
        bit         io, pop, data_rd, stat_rd;
        int         off, ra;
        logic [7:0] status;
        if (r) begin
            m_txq.delete();
            m_rxv = 0; m_rxd = 8'h00; m_ovf = 0; m_ovr = 0; m_mem_in = 8'h00;
            return;
        end
        io      = (a[17:16] == 2'b11);
        off     = int'(a[2:0]);
        ra      = int'(a) & ((1 << RAM_AW) - 1);
        pop     = (m_txq.size() > 0) && trdy;
        data_rd = en && !w && io && off == 0;
        stat_rd = en && !w && io && off == 4;
        status  = {4'b0000, m_ovr, m_ovf, m_txq.size() == TX_DEPTH, m_rxv};
        if (en && !w) begin
            if (!io)          m_mem_in = m_ram.exists(ra) ? m_ram[ra] : 8'h00;
            else if (data_rd) m_mem_in = m_rxv ? m_rxd : 8'h00;
            else if (stat_rd) m_mem_in = status;
            else              m_mem_in = 8'h00;
        end
        if (pop) void'(m_txq.pop_front());
        if (stat_rd) begin m_ovf = 0; m_ovr = 0; end
        if (en && w) begin
            if (!io) m_ram[ra] = d;
            else if (off == 0) begin
                if (m_txq.size() < TX_DEPTH) m_txq.push_back(d);
                else m_ovf = 1;
            end
        end
        if (data_rd) m_rxv = 0;
        if (rv) begin
            if (m_rxv) m_ovr = 1;
            else begin m_rxv = 1; m_rxd = rd; end
        end
    endtask

    task automatic cyc(input bit r, input bit en, input logic [31:0] a, input bit w,
                       input logic [7:0] d, input bit trdy, input bit rv, input logic [7:0] rd);
        rst = r; rdy = en; mem_addr = a; mem_wr = w; mem_out = d;
        tx_ready = trdy; rx_valid = rv; rx_data = rd;
        model_step(r, en, a, w, d, trdy, rv, rd);
        @(posedge clk);
        #1;
        check("mem_in", {24'h0, mem_in}, {24'h0, m_mem_in});
        check("tx_valid", {31'h0, tx_valid}, {31'h0, m_txq.size() > 0});
        check("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, m_txq.size() >= TX_DEPTH - 2});
        if (m_txq.size() > 0) check("tx_data", {24'h0, tx_data}, {24'h0, m_txq[0]});
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cyc(0, 1, a, 1, d, g_trdy, 0, 8'h00);
    endtask
    task automatic rd(input logic [31:0] a);
        cyc(0, 1, a, 0, 8'h00, g_trdy, 0, 8'h00);
    endtask
    task automatic rxp(input logic [7:0] d);
        cyc(0, 1, 32'h0, 0, 8'h00, g_trdy, 1, d);
    endtask
    task automatic do_rst();
        cyc(1, 1, 32'h0, 0, 8'h00, g_trdy, 0, 8'h00);
    endtask

    logic [31:0] ram_addrs [6];
    logic [31:0] io_addrs [4];

    initial begin
        ram_addrs = '{32'h0, 32'h104, 32'h10, 32'hF00010, 32'h1FFFF, 32'h2ABCD};
        io_addrs  = '{32'h30000, 32'h30004, 32'h30002, 32'hFFF30004};
        g_trdy = 0;
        rst = 1; rdy = 0; mem_addr = 0; mem_wr = 0; mem_out = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;

        // Reset state
        do_rst(); do_rst();
        check("rst_mem_in", {24'h0, mem_in}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);

        foreach (ram_addrs[i]) wr(ram_addrs[i], 8'($urandom));

        // Write then read-after-write at 0x104
        wr(32'h104, 8'hA5);
        rd(32'h104);
        check("raw_a5", {24'h0, mem_in}, 32'hA5);
        wr(32'h104, 8'h3D);
        check("wr_holds_mem_in", {24'h0, mem_in}, 32'hA5);

        // Fill TX FIFO with no drain
        do_rst();
        for (int i = 0; i < 17; i++) begin
            wr(32'h30000, 8'(8'h10 + i));
            if (i == 12) check("not_near_full_13", {31'h0, io_buffer_full}, 32'h0);
            if (i == 13) check("near_full_14", {31'h0, io_buffer_full}, 32'h1);
        end
        rd(32'h30004);
        check("status_ovf_full", {24'h0, mem_in}, 32'h06);
        rd(32'h30004);
        check("status_sticky_clr", {24'h0, mem_in}, 32'h02);
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", {31'h0, tx_valid}, 32'h1);
            check("drain_order", {24'h0, tx_data}, 32'(8'h10 + k));
            cyc(0, 1, 32'h0, 0, 8'h00, 1, 0, 8'h00);
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);

        // RX overrun
        rxp(8'h3C);
        rxp(8'h7E);
        rd(32'h30004);
        check("status_overrun", {24'h0, mem_in}, 32'h09);
        rd(32'h30004);
        check("status_ovr_clr", {24'h0, mem_in}, 32'h01);
        rd(32'h30000);
        check("rx_held_byte", {24'h0, mem_in}, 32'h3C);
        rd(32'h30000);
        check("rx_empty_read", {24'h0, mem_in}, 32'h00);

        // Same-cycle DATA read and RX reload
        rxp(8'h11);
        cyc(0, 1, 32'h30000, 0, 8'h00, 0, 1, 8'h55);
        check("rx_pop_reload_old", {24'h0, mem_in}, 32'h11);
        rd(32'h30004);
        check("rx_reload_no_ovr", {24'h0, mem_in}, 32'h01);
        rd(32'h30000);
        check("rx_reload_new", {24'h0, mem_in}, 32'h55);

        // rdy=0 blocks all bus actions
        wr(32'h10, 8'h5A);
        rd(32'h10);
        cyc(0, 0, 32'h10, 1, 8'hFF, 0, 0, 8'h00);
        cyc(0, 0, 32'h30000, 1, 8'hEE, 0, 0, 8'h00);
        cyc(0, 0, 32'h104, 0, 8'h00, 0, 0, 8'h00);
        check("rdy0_mem_in_held", {24'h0, mem_in}, 32'h5A);
        check("rdy0_no_push", {31'h0, tx_valid}, 32'h0);
        rd(32'h10);
        check("rdy0_ram_unchanged", {24'h0, mem_in}, 32'h5A);

        // Push into full FIFO with same-cycle pop
        for (int i = 0; i < 16; i++) wr(32'h30000, 8'($urandom));
        cyc(0, 1, 32'h30000, 1, 8'hC7, 1, 0, 8'h00);
        rd(32'h30004);
        check("full_push_pop_ok", {24'h0, mem_in}, 32'h02);

        // Reset mid-activity
        do_rst();
        for (int i = 0; i < 5; i++) wr(32'h30000, 8'($urandom));
        rxp(8'h99);
        do_rst();
        check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst2_mem_in", {24'h0, mem_in}, 32'h0);
        rd(32'h30004);
        check("rst2_status", {24'h0, mem_in}, 32'h00);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) < 6) ? ram_addrs[$urandom_range(0, 5)]
                                           : io_addrs[$urandom_range(0, 3)];
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, a,
                $urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 2, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
